// File: rtl/obuft_serial_driver.sv
// obuft_serial_driver
//
// Serializes parallel words onto a single half-duplex pad by generating the
// data (I) and tri-state enable (T) inputs of the pad's OBUFT buffer. The pad
// is released (high-Z) whenever no frame is in flight. It is driven high for
// TURN_CYC clocks before and after every burst of words. Words are sent MSB
// first, and each bit is held for CLK_DIV clocks. A new word offered in the
// last clock of the current word is appended to the burst with no gap.
//
// Optional feature (compile-time macro OBUFT_DRV_PARITY_EN):
//   Appends an even-parity bit (XOR of the word) after every word. The
//   parity bit is held for CLK_DIV clocks, and the back-to-back accept window
//   moves to the last clock of the parity bit.
//
// Parameters:
//   WIDTH    data word width in bits (>= 2)
//   CLK_DIV  clocks per serial bit (>= 1)
//   TURN_CYC clocks of driven-high guard before/after each burst (>= 1)
//
// Ports:
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset
//   DIN      word to transmit (MSB first)
//   DIN_VLD  DIN valid
//   DIN_RDY  word accepted when DIN_VLD && DIN_RDY at a rising edge
//   PAD_I    OBUFT data input (registered)
//   PAD_T    OBUFT tri-state enable, 1 = high-Z (registered)
//   BUSY     high in any state other than IDLE
//   DONE     one-clock pulse in the first IDLE clock after a burst
module obuft_serial_driver #(
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 4,
    parameter int TURN_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VLD,
    output logic             DIN_RDY,
    output logic             PAD_I,
    output logic             PAD_T,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CLK_W  = $clog2(CLK_DIV) + 1;
    localparam int BIT_W  = $clog2(WIDTH) + 1;
    localparam int TURN_W = $clog2(TURN_CYC) + 1;

    localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3
`ifdef OBUFT_DRV_PARITY_EN
        ,
        ST_PAR   = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [CLK_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
    logic [WIDTH-1:0]    sreg_q, sreg_d;
    logic                pad_i_q, pad_i_d;
    logic                pad_t_q, pad_t_d;
    logic                done_q, done_d;
    logic                rdy_c;
    logic                enter_st;
`ifdef OBUFT_DRV_PARITY_EN
    logic                par_q, par_d;
`endif

    // Next-state and datapath logic. The pad outputs are registered from the
    // next state, so PAD_I/PAD_T always reflect the state being occupied.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        turn_cnt_d = turn_cnt_q;
        sreg_d     = sreg_q;
        done_d     = 1'b0;
        rdy_c      = 1'b0;
        enter_st   = 1'b0;
`ifdef OBUFT_DRV_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                rdy_c = 1'b1;
                if (DIN_VLD) begin
                    sreg_d   = DIN;
`ifdef OBUFT_DRV_PARITY_EN
                    par_d    = ^DIN;
`endif
                    state_d  = ST_LEAD;
                    enter_st = 1'b1;
                end
            end

            ST_LEAD: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d  = ST_SHIFT;
                    enter_st = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q + TURN_W'(1);
                end
            end

            ST_SHIFT: begin
                if (clk_cnt_q != CLK_LAST) begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end else if (bit_cnt_q != BIT_LAST) begin
                    // Next bit: shift left so the MSB always holds the bit on the pad.
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    sreg_d    = {sreg_q[WIDTH-2:0], 1'b1};
                end else begin
`ifdef OBUFT_DRV_PARITY_EN
                    state_d  = ST_PAR;
                    enter_st = 1'b1;
`else
                    // Last clock of the word: a new word continues the burst.
                    rdy_c    = 1'b1;
                    enter_st = 1'b1;
                    if (DIN_VLD) begin
                        sreg_d  = DIN;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_TRAIL;
                    end
`endif
                end
            end

`ifdef OBUFT_DRV_PARITY_EN
            ST_PAR: begin
                if (clk_cnt_q != CLK_LAST) begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end else begin
                    rdy_c    = 1'b1;
                    enter_st = 1'b1;
                    if (DIN_VLD) begin
                        sreg_d  = DIN;
                        par_d   = ^DIN;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_TRAIL;
                    end
                end
            end
`endif

            ST_TRAIL: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    enter_st = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q + TURN_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                enter_st = 1'b1;
            end
        endcase

        // Every state entry (including SHIFT re-entry for a chained word) restarts the counters.
        if (enter_st) begin
            clk_cnt_d  = '0;
            bit_cnt_d  = '0;
            turn_cnt_d = '0;
        end

        pad_t_d = (state_d == ST_IDLE);
        pad_i_d = 1'b1;
        if (state_d == ST_SHIFT) begin
            pad_i_d = sreg_d[WIDTH-1];
        end
`ifdef OBUFT_DRV_PARITY_EN
        if (state_d == ST_PAR) begin
            pad_i_d = par_d;
        end
`endif
    end

    // Control registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            turn_cnt_q <= '0;
            pad_i_q    <= 1'b1;
            pad_t_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            turn_cnt_q <= turn_cnt_d;
            pad_i_q    <= pad_i_d;
            pad_t_q    <= pad_t_d;
            done_q     <= done_d;
        end
    end

    // Data registers: contents are only meaningful after a load in IDLE/window
    always_ff @(posedge CLK) begin
        sreg_q <= sreg_d;
`ifdef OBUFT_DRV_PARITY_EN
        par_q  <= par_d;
`endif
    end

    assign DIN_RDY = RST_N & rdy_c;
    assign PAD_I   = pad_i_q;
    assign PAD_T   = pad_t_q;
    assign BUSY    = (state_q != ST_IDLE);
    assign DONE    = done_q;

endmodule

// File: tb/tb_obuft_serial_driver.sv
// Testbench for obuft_serial_driver. The driver issues bursts of words. For
// each accepted word it pushes the expected pad waveform (PAD_I sample per
// driven clock) and the expected burst length into scoreboard queues. A
// separate monitor pops and compares on every clock the pad is driven, and
// checks the DONE pulse and length when the pad is released.
module tb_obuft_serial_driver;

    localparam int W    = 8;
    localparam int DIV  = 4;
    localparam int TURN = 2;
`ifdef OBUFT_DRV_PARITY_EN
    localparam int WB = W * DIV + DIV;
`else
    localparam int WB = W * DIV;
`endif

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [W-1:0] DIN = '0;
    logic         DIN_VLD = 1'b0;
    logic         DIN_RDY;
    logic         PAD_I;
    logic         PAD_T;
    logic         BUSY;
    logic         DONE;

    obuft_serial_driver #(
        .WIDTH    (W),
        .CLK_DIV  (DIV),
        .TURN_CYC (TURN)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .DIN     (DIN),
        .DIN_VLD (DIN_VLD),
        .DIN_RDY (DIN_RDY),
        .PAD_I   (PAD_I),
        .PAD_T   (PAD_T),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           idle_from = 0;
    bit           mon_en = 1'b0;
    bit           exp_bits[$];
    int           exp_len[$];
    logic [W-1:0] burst_w[4];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: pad waveform while driven, one entry per clock.
    function automatic void push_ones(input int n);
        repeat (n) exp_bits.push_back(1'b1);
    endfunction

    function automatic void push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            repeat (DIV) exp_bits.push_back(w[i]);
        end
`ifdef OBUFT_DRV_PARITY_EN
        repeat (DIV) exp_bits.push_back(^w);
`endif
    endfunction

    task automatic wait_rdy(output bit ok);
        int t;
        t = 0;
        while (!DIN_RDY && t < 300) begin
            @(negedge CLK);
            t++;
        end
        ok = DIN_RDY;
        if (!ok) fail_now("accept_timeout");
    endtask

    // Sends burst_w[0..n-1] as one burst after 'gap' idle negedges. The first
    // word is accepted at the later of the offer cycle and the first IDLE
    // cycle. Each following word is accepted in the last clock of the previous word.
    task automatic send_burst(input int n, input int gap);
        int exp_acc;
        int win;
        bit ok;
        repeat (gap) begin
            @(negedge CLK);
            DIN = W'($urandom);
        end
        DIN     = burst_w[0];
        DIN_VLD = 1'b1;
        exp_acc = (cyc > idle_from) ? cyc : idle_from;
        wait_rdy(ok);
        if (!ok) begin
            DIN_VLD = 1'b0;
            return;
        end
        chk("accept_cycle", cyc, exp_acc);
        push_ones(TURN);
        push_word(burst_w[0]);
        win = cyc + TURN + WB;
        for (int k = 1; k < n; k++) begin
            @(negedge CLK);
            DIN = burst_w[k];
            wait_rdy(ok);
            if (!ok) begin
                DIN_VLD = 1'b0;
                return;
            end
            chk("b2b_accept_cycle", cyc, win);
            push_word(burst_w[k]);
            win = cyc + WB;
        end
        push_ones(TURN);
        exp_len.push_back(2 * TURN + n * WB);
        @(negedge CLK);
        DIN_VLD = 1'b0;
        while (cyc <= win) begin
            @(negedge CLK);
            DIN = W'($urandom);
        end
        idle_from = win + TURN + 1;
    endtask

    // Monitor / scoreboard checker
    initial begin
        bit in_burst;
        int blen;
        bit eb;
        in_burst = 1'b0;
        blen     = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N || !mon_en) begin
                in_burst = 1'b0;
                blen     = 0;
            end else begin
                chk("busy_vs_pad_t", BUSY, !PAD_T);
                if (!PAD_T) begin
                    in_burst = 1'b1;
                    blen++;
                    if (exp_bits.size() == 0) begin
                        fail_now("pad_driven_unexpectedly");
                    end else begin
                        eb = exp_bits.pop_front();
                        chk("pad_i", PAD_I, eb);
                    end
                    chk("done_in_burst", DONE, 0);
                end else begin
                    chk("pad_i_released", PAD_I, 1);
                    if (in_burst) begin
                        chk("done_pulse", DONE, 1);
                        if (exp_len.size() == 0) fail_now("burst_not_expected");
                        else chk("burst_len", blen, exp_len.pop_front());
                        in_burst = 1'b0;
                        blen     = 0;
                    end else begin
                        chk("done_idle", DONE, 0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        fail_now("global_timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        int exp_acc;
        int acc;
        int t;
        int nb;
        int gp;
        bit ok;

        repeat (3) @(negedge CLK);
        chk("rst_pad_t", PAD_T, 1);
        chk("rst_pad_i", PAD_I, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_din_rdy", DIN_RDY, 0);
        RST_N     = 1'b1;
        idle_from = cyc;
        mon_en    = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            chk("idle_rdy", DIN_RDY, 1);
        end

        // Single word.
        burst_w[0] = 8'hA5;
        send_burst(1, 0);

        // Offered during TRAIL of the previous burst, then back-to-back pair.
        burst_w[0] = 8'hFF;
        burst_w[1] = 8'h00;
        send_burst(2, 0);

        // Mid-frame reset during DIN[3] of 8'h3C.
        repeat (3) @(negedge CLK);
        DIN     = 8'h3C;
        DIN_VLD = 1'b1;
        exp_acc = (cyc > idle_from) ? cyc : idle_from;
        wait_rdy(ok);
        chk("rst_word_accept_cycle", cyc, exp_acc);
        push_ones(TURN);
        push_word(8'h3C);
        acc = cyc;
        @(negedge CLK);
        DIN_VLD = 1'b0;
        while (cyc < acc + TURN + 1 + 4 * DIV + 1) @(negedge CLK);
        chk("pre_rst_pad_t", PAD_T, 0);
        #2;
        RST_N = 1'b0;
        exp_bits.delete();
        exp_len.delete();
        #1;
        chk("async_rst_pad_t", PAD_T, 1);
        chk("async_rst_pad_i", PAD_I, 1);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_din_rdy", DIN_RDY, 0);
        chk("async_rst_done", DONE, 0);
        repeat (3) @(negedge CLK);
        RST_N     = 1'b1;
        idle_from = cyc;

        burst_w[0] = W'($urandom);
        send_burst(1, 2);

        // Randomized bursts.
        for (int b = 0; b < 25; b++) begin
            nb = $urandom_range(1, 3);
            gp = $urandom_range(0, 4);
            for (int k = 0; k < 4; k++) burst_w[k] = W'($urandom);
            send_burst(nb, gp);
        end

        t = 0;
        while ((exp_len.size() != 0 || BUSY) && t < 1000) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 1000) fail_now("drain_timeout");
        repeat (2) @(negedge CLK);
        chk("exp_bits_left", exp_bits.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
